// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: bus sizes, control bundle,
// EX/MEM and MEM/WB payloads and the access FSM encoding.
package memory_stage_pkg;

    localparam int XLEN = 64;

    typedef logic [1:0] mem_size_t;

    localparam mem_size_t MSIZE_B = 2'd0;
    localparam mem_size_t MSIZE_H = 2'd1;
    localparam mem_size_t MSIZE_W = 2'd2;
    localparam mem_size_t MSIZE_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ADDR,
        WAIT_DATA
    } memop_state_t;

    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      mem_unsigned;
        mem_size_t mem_size;
    } control_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] pc;
        control_t        ctl;
        logic [4:0]      dst;
        logic            is_bubble;
    } execute_data_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] pc;
        control_t        ctl;
        logic [4:0]      dst;
        logic            is_bubble;
        logic            misalign;
    } memory_data_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane helper: store shifter/strobe, load extractor/extender
// and natural-alignment check for a 64-bit data bus.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]      off,
    input  mem_size_t       size,
    input  logic            uns,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] sdata,
    output logic [7:0]      strobe,
    output logic [XLEN-1:0] ldata,
    output logic            misalign
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      lanes;
    logic [2:0]      mask;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        sdata   = wdata << {off, 3'b000};
        lanes   = 8'h01;
        mask    = 3'b000;
        ldata   = shifted;
        unique case (size)
            MSIZE_B: begin
                lanes = 8'h01;
                mask  = 3'b000;
                ldata = {{56{shifted[7] & ~uns}}, shifted[7:0]};
            end
            MSIZE_H: begin
                lanes = 8'h03;
                mask  = 3'b001;
                ldata = {{48{shifted[15] & ~uns}}, shifted[15:0]};
            end
            MSIZE_W: begin
                lanes = 8'h0F;
                mask  = 3'b011;
                ldata = {{32{shifted[31] & ~uns}}, shifted[31:0]};
            end
            MSIZE_D: begin
                lanes = 8'hFF;
                mask  = 3'b111;
                ldata = shifted;
            end
            default: ;
        endcase
        strobe   = lanes << off;
        misalign = |(off & mask);
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-bus requests, stalls until the
// response arrives and formats load results for MEM/WB.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  execute_data_t   dataE,
    output memory_data_t    dataM,
    output logic            stallM,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data
);

    memop_state_t    state, state_n;
    logic            memop, req, complete;
    logic            misalign;
    logic [7:0]      strobe;
    logic [XLEN-1:0] sdata, ldata;

    mem_align u_align (
        .off      (dataE.result[2:0]),
        .size     (dataE.ctl.mem_size),
        .uns      (dataE.ctl.mem_unsigned),
        .wdata    (dataE.wdata),
        .rdata    (dresp_data),
        .sdata    (sdata),
        .strobe   (strobe),
        .ldata    (ldata),
        .misalign (misalign)
    );

    assign memop = !dataE.is_bubble
                 && (dataE.ctl.mem_read || dataE.ctl.mem_write);
    assign req   = memop && !misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        complete   = 1'b0;
        dreq_valid = 1'b0;
        unique case (state)
            IDLE, WAIT_ADDR: begin
                if (req) begin
                    dreq_valid = 1'b1;
                    if (dresp_addr_ok && dresp_data_ok) begin
                        complete = 1'b1;
                        state_n  = IDLE;
                    end else if (dresp_addr_ok) begin
                        state_n = WAIT_DATA;
                    end else begin
                        state_n = WAIT_ADDR;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT_DATA: begin
                if (dresp_data_ok) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        stallM = req && !complete;
        if (!reset) begin
            dreq_valid = 1'b0;
            stallM     = 1'b0;
        end
    end

    assign dreq_addr   = dataE.result;
    assign dreq_size   = {1'b0, dataE.ctl.mem_size};
    assign dreq_strobe = dataE.ctl.mem_write ? strobe : 8'h00;
    assign dreq_data   = sdata;

    always_comb begin
        dataM.result    = dataE.result;
        dataM.pc        = dataE.pc;
        dataM.ctl       = dataE.ctl;
        dataM.dst       = dataE.dst;
        dataM.is_bubble = dataE.is_bubble || stallM;
        dataM.misalign  = memop && misalign;
        if (complete && dataE.ctl.mem_read)
            dataM.result = ldata;
        if (!reset) begin
            dataM           = '0;
            dataM.pc        = RESET_PC;
            dataM.is_bubble = 1'b1;
        end
    end

    // A response may never overtake the acceptance of its request.
    a_no_early_data : assert property (@(posedge clk) disable iff (!reset)
        !(state != WAIT_DATA && dresp_data_ok && !dresp_addr_ok));

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage with a byte-level reference model
// of load extension, store lanes, alignment and bus handshake timing.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    execute_data_t   dataE;
    memory_data_t    dataM;
    logic            stallM, dreq_valid;
    logic [63:0]     dreq_addr, dreq_data, rdata;
    logic [2:0]      dreq_size;
    logic [7:0]      dreq_strobe;
    logic            addr_ok, data_ok;

    int checks = 0;
    int errs   = 0;

    memory_stage dut (
        .clk           (clk),
        .reset         (reset),
        .dataE         (dataE),
        .dataM         (dataM),
        .stallM        (stallM),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (addr_ok),
        .dresp_data_ok (data_ok),
        .dresp_data    (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] d,
            input int off, input int n, input bit uns);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v[8*i +: 8] = d[8*(off+i) +: 8];
        if (!uns && n < 8 && v[8*n-1])
            for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] ref_strobe(input int off, input int n);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < n && off + i < 8; i++) s[off+i] = 1'b1;
        return s;
    endfunction

    task automatic idle_in();
        dataE           = '0;
        dataE.is_bubble = 1'b1;
        addr_ok         = 1'b0;
        data_ok         = 1'b0;
        rdata           = {$urandom, $urandom};
    endtask

    // Call just after a rising edge; returns just after a rising edge.
    task automatic run_op(input bit bub, input bit rd, input bit wr,
            input bit uns, input int sz, input logic [63:0] addr,
            input logic [63:0] wdata, input logic [63:0] rd_data,
            input int da, input int dd);
        control_t    c;
        logic [63:0] pc;
        int          n, off, last;
        bit          memop, mis, go;
        c              = '0;
        c.reg_write    = rd || !wr;
        c.mem_read     = rd;
        c.mem_write    = wr;
        c.mem_unsigned = uns;
        c.mem_size     = mem_size_t'(sz);
        pc             = {$urandom, $urandom};
        dataE.result    = addr;
        dataE.wdata     = wdata;
        dataE.pc        = pc;
        dataE.ctl       = c;
        dataE.dst       = 5'($urandom);
        dataE.is_bubble = bub;
        n     = 1 << sz;
        off   = int'(addr[2:0]);
        memop = !bub && (rd || wr);
        mis   = memop && (off % n != 0);
        go    = memop && !mis;
        last  = go ? dd : 0;
        for (int k = 0; k <= last; k++) begin
            addr_ok = go && (k == da);
            data_ok = go && (k == dd);
            rdata   = (go && k == dd) ? rd_data : {$urandom, $urandom};
            @(negedge clk);
            check("stall", stallM, k < last);
            check("valid", dreq_valid, go && k <= da);
            check("bubble", dataM.is_bubble, bub || k < last);
            if (go && k <= da) begin
                check("addr", dreq_addr, addr);
                check("size", dreq_size, sz);
                check("strobe", dreq_strobe, wr ? ref_strobe(off, n) : 8'h00);
                if (wr) check("sdata", dreq_data, wdata << (8 * off));
            end
            if (k == last) begin
                check("result", dataM.result,
                      (go && rd) ? ref_load(rd_data, off, n, uns) : addr);
                check("misalign", dataM.misalign, mis);
                check("pc", dataM.pc, pc);
            end
            @(posedge clk);
            #1;
        end
        idle_in();
    endtask

    initial begin
        logic [63:0] a, d;
        int          kind, sz, da;
        reset = 1'b0;
        idle_in();
        #3;
        check("rst_valid", dreq_valid, 0);
        check("rst_stall", stallM, 0);
        check("rst_bubble", dataM.is_bubble, 1);
        check("rst_pc", dataM.pc, 64'h8000_0000);
        check("rst_result", dataM.result, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(0, 0, 0, 0, 3, 64'h1234, 0, 0, 0, 0);
        run_op(0, 1, 0, 0, 3, 64'h8000_0008, 0,
               64'hDEAD_BEEF_0000_0001, 0, 0);
        run_op(0, 1, 0, 0, 0, 64'h8000_0003, 0,
               64'h1111_1111_8011_1111, 2, 4);
        run_op(0, 0, 1, 0, 1, 64'h8000_0006, 64'hABCD, 0, 0, 1);
        run_op(0, 1, 0, 0, 2, 64'h8000_0002, 0, 0, 0, 0);
        run_op(1, 1, 0, 0, 3, 64'h8000_0010, 0, 0, 0, 0);

        // Reset while waiting for load data.
        dataE.result    = 64'h8000_0020;
        dataE.pc        = 64'h4;
        dataE.ctl       = '0;
        dataE.ctl.mem_read = 1'b1;
        dataE.ctl.mem_size = MSIZE_D;
        dataE.is_bubble = 1'b0;
        addr_ok = 1'b1;
        @(negedge clk);
        check("wd_stall", stallM, 1);
        @(posedge clk);
        #1;
        addr_ok = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", dreq_valid, 0);
        check("ar_stall", stallM, 0);
        check("ar_bubble", dataM.is_bubble, 1);
        check("ar_pc", dataM.pc, 64'h8000_0000);
        check("ar_result", dataM.result, 0);
        check("ar_ctl", 64'(dataM.ctl), 0);
        check("ar_dst", 64'(dataM.dst), 0);
        idle_in();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op(0, 1, 0, 1, 2, 64'h8000_0024, 0,
               64'h8765_4321_0000_0000, 0, 0);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 3);
            sz   = $urandom_range(0, 3);
            a    = {$urandom, $urandom};
            d    = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1)
                a = a & ~64'((1 << sz) - 1);
            da = $urandom_range(0, 3);
            run_op(kind == 3, kind == 1 || kind == 3, kind == 2,
                   1'($urandom), sz, a, {$urandom, $urandom}, d,
                   da, da + $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
